// File: rtl/tmds_decoder_align.sv
// TMDS receive channel: finds the 10-bit word boundary via bitslip requests,
// then decodes each word into pixel byte, control bits and data enable.
module tmds_decoder_align #(
  parameter int unsigned CTRL_RUN       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned SLIP_SETTLE    = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536
) (
  input  logic       clk_1x_in,
  input  logic       reset_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] pixel_data,
  output logic [1:0] ctrl_signals,
  output logic       de,
  output logic       bitslip,
  output logic       aligned
);

  localparam int unsigned TMAX_A  = (SEARCH_TIMEOUT > SLIP_SETTLE) ? SEARCH_TIMEOUT : SLIP_SETTLE;
  localparam int unsigned TMAX    = (TMAX_A > LOCK_TIMEOUT) ? TMAX_A : LOCK_TIMEOUT;
  localparam int unsigned TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned RUN_W   = $clog2(CTRL_RUN + 1);

  localparam logic [TIMER_W-1:0] SEARCH_LAST = TIMER_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SLIP_SETTLE - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [RUN_W-1:0]   RUN_LAST    = RUN_W'(CTRL_RUN - 1);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               bitslip_q, bitslip_d;
  logic               aligned_q, aligned_d;
  logic [7:0]         pixel_q, pixel_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               de_q, de_d;

  logic       is_tok_c;
  logic [1:0] tok_val_c;
  logic [7:0] t_c;
  logic [7:0] q_c;

  // Control token recognition
  always_comb begin
    is_tok_c  = 1'b1;
    tok_val_c = 2'b00;
    case (tmds_in)
      10'b1101010100: tok_val_c = 2'b00;
      10'b0010101011: tok_val_c = 2'b01;
      10'b0101010100: tok_val_c = 2'b10;
      10'b1010101011: tok_val_c = 2'b11;
      default:        is_tok_c  = 1'b0;
    endcase
  end

  // TMDS data word decode (undo inversion, then undo XOR/XNOR chain)
  always_comb begin
    t_c    = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
    q_c    = 8'h00;
    q_c[0] = t_c[0];
    for (int i = 1; i < 8; i++) begin
      q_c[i] = tmds_in[8] ? (t_c[i] ^ t_c[i-1]) : ~(t_c[i] ^ t_c[i-1]);
    end
  end

  // Alignment state machine and output next-state
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    timer_d   = timer_q;
    bitslip_d = 1'b0;
    pixel_d   = 8'h00;
    de_d      = 1'b0;
    ctrl_d    = ctrl_q;

    case (state_q)
      ST_SEARCH: begin
        run_d   = is_tok_c ? run_q + RUN_W'(1) : '0;
        timer_d = timer_q + TIMER_W'(1);
        // Lock takes priority over a coincident search timeout
        if (is_tok_c && (run_q == RUN_LAST)) begin
          state_d = ST_LOCKED;
          run_d   = '0;
          timer_d = '0;
        end else if (timer_q == SEARCH_LAST) begin
          state_d   = ST_SETTLE;
          bitslip_d = 1'b1;
          run_d     = '0;
          timer_d   = '0;
        end
      end
      ST_SETTLE: begin
        run_d = '0;
        if (timer_q == SETTLE_LAST) begin
          state_d = ST_SEARCH;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_LOCKED: begin
        run_d = '0;
        if (is_tok_c) begin
          timer_d = '0;
        end else if (timer_q == LOCK_LAST) begin
          state_d = ST_SEARCH;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = ST_SEARCH;
        run_d   = '0;
        timer_d = '0;
      end
    endcase

    if (is_tok_c) begin
      ctrl_d = tok_val_c;
    end else if (state_q == ST_LOCKED) begin
      de_d    = 1'b1;
      pixel_d = q_c;
    end

    aligned_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_1x_in) begin
    if (reset_in) begin
      state_q   <= ST_SEARCH;
      run_q     <= '0;
      timer_q   <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      pixel_q   <= 8'h00;
      ctrl_q    <= 2'b00;
      de_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      timer_q   <= timer_d;
      bitslip_q <= bitslip_d;
      aligned_q <= aligned_d;
      pixel_q   <= pixel_d;
      ctrl_q    <= ctrl_d;
      de_q      <= de_d;
    end
  end

  assign pixel_data   = pixel_q;
  assign ctrl_signals = ctrl_q;
  assign de           = de_q;
  assign bitslip      = bitslip_q;
  assign aligned      = aligned_q;

endmodule
